// File: rtl/alarm_ringer.sv
// Alarm ringer: edge-triggered RING/SNOOZE/IDLE controller with beep pattern and timeouts.
// Optional feature macro: SNOOZE_LIMIT_EN (caps snoozes per alarm at MAX_SNOOZE).
`timescale 1ns/1ps
module alarm_ringer #(
  parameter int unsigned BEEP_ON_CYC    = 25_000_000,
  parameter int unsigned BEEP_OFF_CYC   = 25_000_000,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sec_tick,
  input  logic alarm_trigger,
  input  logic alarm_en,
  input  logic stop_btn,
  input  logic snooze_btn,
  output logic buzzer,
  output logic ringing,
  output logic snoozed
);

  localparam int unsigned BEEP_PER = BEEP_ON_CYC + BEEP_OFF_CYC;
  localparam int unsigned BEEP_W   = (BEEP_PER > 1) ? $clog2(BEEP_PER) : 1;
  localparam int unsigned SEC_MAX  = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int unsigned SEC_W    = (SEC_MAX > 0) ? $clog2(SEC_MAX + 1) : 1;

  if (BEEP_ON_CYC == 0 || BEEP_OFF_CYC == 0 || RING_TIMEOUT_S == 0 || SNOOZE_S == 0 ||
      MAX_SNOOZE >= 65536) begin : g_bad_cfg
    $error("alarm_ringer: invalid parameter set");
  end

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t            state;
  logic              trig_q;
  logic [BEEP_W-1:0] beep_cnt;
  logic [BEEP_W-1:0] beep_nxt;
  logic [SEC_W-1:0]  sec_cnt;
  logic              start;
  logic              ring_tmo;
  logic              snz_tmo;
  logic              snooze_ok;

`ifdef SNOOZE_LIMIT_EN
  localparam int unsigned SNZ_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  logic [SNZ_W-1:0] snz_cnt;
`endif

  always_comb begin
    start     = alarm_trigger & ~trig_q & alarm_en;
    beep_nxt  = (beep_cnt == BEEP_W'(BEEP_PER - 1)) ? '0 : beep_cnt + BEEP_W'(1);
    ring_tmo  = sec_tick && (sec_cnt == SEC_W'(RING_TIMEOUT_S - 1));
    snz_tmo   = sec_tick && (sec_cnt == SEC_W'(SNOOZE_S - 1));
`ifdef SNOOZE_LIMIT_EN
    snooze_ok = snooze_btn && (snz_cnt != SNZ_W'(MAX_SNOOZE));
`else
    snooze_ok = snooze_btn;
`endif
  end

  // Outputs are assigned alongside the state so they reflect it one cycle after the event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      trig_q   <= 1'b1;
      beep_cnt <= '0;
      sec_cnt  <= '0;
      buzzer   <= 1'b0;
      ringing  <= 1'b0;
      snoozed  <= 1'b0;
`ifdef SNOOZE_LIMIT_EN
      snz_cnt  <= '0;
`endif
    end else begin
      trig_q <= alarm_trigger;
      if (!alarm_en || (state == IDLE && !start) ||
          (state == RING && (stop_btn || (!snooze_ok && ring_tmo))) ||
          (state == SNOOZE && stop_btn)) begin
        state    <= IDLE;
        beep_cnt <= '0;
        sec_cnt  <= '0;
        buzzer   <= 1'b0;
        ringing  <= 1'b0;
        snoozed  <= 1'b0;
`ifdef SNOOZE_LIMIT_EN
        snz_cnt  <= '0;
`endif
      end else if ((state == IDLE) || (state == SNOOZE && (start || snz_tmo))) begin
        state    <= RING;
        beep_cnt <= '0;
        sec_cnt  <= '0;
        buzzer   <= 1'b1;
        ringing  <= 1'b1;
        snoozed  <= 1'b0;
      end else if (state == RING && snooze_ok) begin
        state    <= SNOOZE;
        beep_cnt <= '0;
        sec_cnt  <= '0;
        buzzer   <= 1'b0;
        ringing  <= 1'b0;
        snoozed  <= 1'b1;
`ifdef SNOOZE_LIMIT_EN
        snz_cnt  <= snz_cnt + SNZ_W'(1);
`endif
      end else begin
        if (state == RING) begin
          beep_cnt <= beep_nxt;
          buzzer   <= (beep_nxt < BEEP_W'(BEEP_ON_CYC));
        end
        if (sec_tick) sec_cnt <= sec_cnt + SEC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed self-checking bench for alarm_ringer (ON=4, OFF=2, timeout 3 s, snooze 2 s, max 2 snoozes).
`timescale 1ns/1ps
module tb_alarm_ringer;

  logic clk = 1'b0;
  logic rst, sec_tick, alarm_trigger, alarm_en, stop_btn, snooze_btn;
  logic buzzer, ringing, snoozed;
  int tests  = 0;
  int failed = 0;

  alarm_ringer #(
    .BEEP_ON_CYC(4), .BEEP_OFF_CYC(2), .RING_TIMEOUT_S(3), .SNOOZE_S(2), .MAX_SNOOZE(2)
  ) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .alarm_trigger(alarm_trigger),
    .alarm_en(alarm_en), .stop_btn(stop_btn), .snooze_btn(snooze_btn),
    .buzzer(buzzer), .ringing(ringing), .snoozed(snoozed)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic raise();
    alarm_trigger = 1'b0; step(1);
    alarm_trigger = 1'b1; step(1);
  endtask

  task automatic tick();
    step(2);
    sec_tick = 1'b1; step(1); sec_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; alarm_trigger = 1'b0; alarm_en = 1'b1;
    sec_tick = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
    step(2);
    tests++; if ({buzzer, ringing, snoozed} !== 3'b000) begin failed++; $display("FAIL reset_outputs got=%b exp=000", {buzzer, ringing, snoozed}); end
    rst = 1'b1; step(3);
    tests++; if ({buzzer, ringing, snoozed} !== 3'b000) begin failed++; $display("FAIL post_reset_idle got=%b exp=000", {buzzer, ringing, snoozed}); end
  endtask

  task automatic test_ring_pattern();
    step(5);
    raise();
    for (int i = 0; i < 30; i++) begin
      tests++; if (ringing !== 1'b1) begin failed++; $display("FAIL pattern_ringing cyc=%0d got=%b exp=1", i, ringing); end
      tests++; if (buzzer !== ((i % 6) < 4)) begin failed++; $display("FAIL pattern_buzzer cyc=%0d got=%b exp=%b", i, buzzer, (i % 6) < 4); end
      step(1);
    end
    stop_btn = 1'b1; step(1); stop_btn = 1'b0;
    tests++; if ({buzzer, ringing} !== 2'b00) begin failed++; $display("FAIL stop_idle got=%b exp=00", {buzzer, ringing}); end
    step(20);
    tests++; if (ringing !== 1'b0) begin failed++; $display("FAIL no_refire got=%b exp=0", ringing); end
  endtask

  task automatic test_timeout();
    raise();
    tests++; if (ringing !== 1'b1) begin failed++; $display("FAIL tmo_entry got=%b exp=1", ringing); end
    tick(); tick();
    tests++; if (ringing !== 1'b1) begin failed++; $display("FAIL tmo_early got=%b exp=1", ringing); end
    tick();
    tests++; if ({buzzer, ringing, snoozed} !== 3'b000) begin failed++; $display("FAIL tmo_idle got=%b exp=000", {buzzer, ringing, snoozed}); end
  endtask

  task automatic test_snooze();
    raise();
    step(3);
    snooze_btn = 1'b1; step(1); snooze_btn = 1'b0;
    tests++; if ({buzzer, ringing, snoozed} !== 3'b001) begin failed++; $display("FAIL snooze_entry got=%b exp=001", {buzzer, ringing, snoozed}); end
    tick();
    tests++; if (snoozed !== 1'b1) begin failed++; $display("FAIL snooze_hold got=%b exp=1", snoozed); end
    tick();
    tests++; if ({buzzer, ringing, snoozed} !== 3'b110) begin failed++; $display("FAIL snooze_rering got=%b exp=110", {buzzer, ringing, snoozed}); end
    snooze_btn = 1'b1; step(1); snooze_btn = 1'b0;
    snooze_btn = 1'b1; step(1); snooze_btn = 1'b0;
    tests++; if (snoozed !== 1'b1) begin failed++; $display("FAIL snooze_btn_ignored got=%b exp=1", snoozed); end
    alarm_trigger = 1'b0; step(1);
    alarm_trigger = 1'b1; step(1);
    tests++; if ({buzzer, ringing, snoozed} !== 3'b110) begin failed++; $display("FAIL snooze_start_rering got=%b exp=110", {buzzer, ringing, snoozed}); end
    stop_btn = 1'b1; step(1); stop_btn = 1'b0;
    tests++; if ({buzzer, ringing, snoozed} !== 3'b000) begin failed++; $display("FAIL snooze_stop got=%b exp=000", {buzzer, ringing, snoozed}); end
  endtask

  task automatic test_priority();
    raise();
    stop_btn = 1'b1; snooze_btn = 1'b1; step(1); stop_btn = 1'b0; snooze_btn = 1'b0;
    tests++; if ({ringing, snoozed} !== 2'b00) begin failed++; $display("FAIL stop_beats_snooze got=%b exp=00", {ringing, snoozed}); end
    alarm_trigger = 1'b0; step(1);
    alarm_trigger = 1'b1; stop_btn = 1'b1; step(1); stop_btn = 1'b0;
    tests++; if (ringing !== 1'b1) begin failed++; $display("FAIL start_beats_btn got=%b exp=1", ringing); end
    snooze_btn = 1'b1; step(1); snooze_btn = 1'b0;
    alarm_en = 1'b0; step(1);
    tests++; if ({ringing, snoozed} !== 2'b00) begin failed++; $display("FAIL en_low_snooze got=%b exp=00", {ringing, snoozed}); end
    raise();
    tests++; if (ringing !== 1'b0) begin failed++; $display("FAIL en_low_blocks got=%b exp=0", ringing); end
    alarm_en = 1'b1; step(3);
    tests++; if (ringing !== 1'b0) begin failed++; $display("FAIL en_high_level got=%b exp=0", ringing); end
  endtask

  task automatic test_reset_trigger_high();
    rst = 1'b0; alarm_trigger = 1'b1; step(2);
    rst = 1'b1; step(5);
    tests++; if (ringing !== 1'b0) begin failed++; $display("FAIL trig_high_at_reset got=%b exp=0", ringing); end
    raise();
    tests++; if (ringing !== 1'b1) begin failed++; $display("FAIL trig_retoggle got=%b exp=1", ringing); end
    #2 rst = 1'b0; #1;
    tests++; if ({buzzer, ringing, snoozed} !== 3'b000) begin failed++; $display("FAIL async_reset got=%b exp=000", {buzzer, ringing, snoozed}); end
    @(negedge clk); rst = 1'b1; alarm_trigger = 1'b0; step(2);
  endtask

  task automatic test_snooze_limit();
    raise();
    for (int s = 0; s < 2; s++) begin
      snooze_btn = 1'b1; step(1); snooze_btn = 1'b0;
      tests++; if (snoozed !== 1'b1) begin failed++; $display("FAIL limit_snooze%0d got=%b exp=1", s, snoozed); end
      tick(); tick();
      tests++; if (ringing !== 1'b1) begin failed++; $display("FAIL limit_rering%0d got=%b exp=1", s, ringing); end
    end
    snooze_btn = 1'b1; step(1); snooze_btn = 1'b0;
`ifdef SNOOZE_LIMIT_EN
    tests++; if ({ringing, snoozed} !== 2'b10) begin failed++; $display("FAIL limit_third_ignored got=%b exp=10", {ringing, snoozed}); end
    tick(); tick();
    tests++; if (ringing !== 1'b1) begin failed++; $display("FAIL limit_still_ring got=%b exp=1", ringing); end
    tick();
    tests++; if (ringing !== 1'b0) begin failed++; $display("FAIL limit_timeout got=%b exp=0", ringing); end
`else
    tests++; if ({ringing, snoozed} !== 2'b01) begin failed++; $display("FAIL unlimited_third got=%b exp=01", {ringing, snoozed}); end
    stop_btn = 1'b1; step(1); stop_btn = 1'b0;
    tests++; if (snoozed !== 1'b0) begin failed++; $display("FAIL unlimited_stop got=%b exp=0", snoozed); end
`endif
  endtask

  initial begin
    test_reset();
    test_ring_pattern();
    test_timeout();
    test_snooze();
    test_priority();
    test_reset_trigger_high();
    test_snooze_limit();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
